// File: rtl/keep_zip_pkg.sv
// Shared definitions for the 4:1 sample zipper and unzipper.
// Both sides read the lane map from here so it cannot diverge.
package keep_zip_pkg;

    localparam int ZIP_LANES  = 4;
    localparam int ZIP_BYTE_W = 8;

    // Bit offset of each lane's symbol byte in the packed word, lane 0 first out.
    localparam logic [ZIP_LANES-1:0][4:0] LANE_LSB = {5'd0, 5'd24, 5'd16, 5'd8};

    localparam int EXPAND_TOP = 0;
    localparam int EXPAND_IQ  = 1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } unzip_state_e;

endpackage

// File: rtl/zip_lane_expand.sv
// Expands one compressed 8-bit symbol into a 32-bit {I16,Q16} sample.
// Purely bitwise placement: no sign extension, rounding or saturation.
module zip_lane_expand
    import keep_zip_pkg::*;
(
    input  logic [ZIP_BYTE_W-1:0] sym,
    input  logic                  mode_iq,
    output logic [31:0]           sample
);

    always_comb begin
        sample = '0;
        if (mode_iq) begin
            sample = {sym[7:4], 12'h000, sym[3:0], 12'h000};
        end else begin
            sample = {sym, 24'h000000};
        end
    end

endmodule

// File: rtl/keep_one_in_n_unzip.sv
// Receive-side unzipper: one packed word of four symbols in, four expanded samples out,
// one per beat, with back-to-back words accepted on the last lane without a bubble.
module keep_one_in_n_unzip
    import keep_zip_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int EXPAND_MODE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready
);

    localparam logic       MODE_IQ   = (EXPAND_MODE == EXPAND_IQ);
    localparam logic [1:0] LAST_LANE = 2'(ZIP_LANES - 1);

    unzip_state_e     state_q, state_d;
    logic [1:0]       lane_q, lane_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             tlast_q, tlast_d;

    logic [ZIP_BYTE_W-1:0] lane_sym;
    logic [31:0]           lane_sample;
    logic                  in_fire;
    logic                  out_fire;
    logic                  on_last_lane;

    assign lane_sym     = word_q[LANE_LSB[lane_q] +: ZIP_BYTE_W];
    assign on_last_lane = (lane_q == LAST_LANE);

    zip_lane_expand u_expand (
        .sym     (lane_sym),
        .mode_iq (MODE_IQ),
        .sample  (lane_sample)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            lane_q  <= 2'd0;
            word_q  <= '0;
            tlast_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            word_q  <= word_d;
            tlast_q <= tlast_d;
        end
    end

    // Ready only looks at o_tready, never at i_tvalid, so no handshake loop forms upstream.
    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        word_d   = word_q;
        tlast_d  = tlast_q;
        o_tvalid = 1'b0;
        o_tdata  = '0;
        o_tlast  = 1'b0;
        i_tready = (state_q == ST_EMPTY) | (o_tready & on_last_lane);
        in_fire  = i_tvalid & i_tready;
        out_fire = 1'b0;

        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    word_d  = i_tdata;
                    tlast_d = i_tlast;
                    lane_d  = 2'd0;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                o_tvalid = 1'b1;
                o_tdata  = lane_sample;
                o_tlast  = tlast_q & on_last_lane;
                out_fire = o_tready;
                if (out_fire) begin
                    if (!on_last_lane) begin
                        lane_d = lane_q + 2'd1;
                    end else if (in_fire) begin
                        word_d  = i_tdata;
                        tlast_d = i_tlast;
                        lane_d  = 2'd0;
                    end else begin
                        lane_d  = 2'd0;
                        state_d = ST_EMPTY;
                    end
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

endmodule

// File: tb/tb_keep_one_in_n_unzip.sv
// Bench for keep_one_in_n_unzip: both expansion modes side by side against a sample-queue model.
module tb_keep_one_in_n_unzip;

    logic        clk;
    logic        reset;
    logic [31:0] i_tdata;
    logic        i_tlast;
    logic        i_tvalid;
    logic        o_tready;

    logic        i_tready0, i_tready1;
    logic [31:0] o_tdata0, o_tdata1;
    logic        o_tlast0, o_tlast1;
    logic        o_tvalid0, o_tvalid1;

    typedef struct {
        logic [7:0] sym;
        logic       last;
    } beat_t;

    beat_t model_q[$];
    int    checks = 0;
    int    errors = 0;
    logic  last_in_fire;
    logic  last_out_valid;

    keep_one_in_n_unzip #(.WIDTH(32), .EXPAND_MODE(0)) dut0 (
        .clk      (clk),
        .reset    (reset),
        .i_tdata  (i_tdata),
        .i_tlast  (i_tlast),
        .i_tvalid (i_tvalid),
        .i_tready (i_tready0),
        .o_tdata  (o_tdata0),
        .o_tlast  (o_tlast0),
        .o_tvalid (o_tvalid0),
        .o_tready (o_tready)
    );

    keep_one_in_n_unzip #(.WIDTH(32), .EXPAND_MODE(1)) dut1 (
        .clk      (clk),
        .reset    (reset),
        .i_tdata  (i_tdata),
        .i_tlast  (i_tlast),
        .i_tvalid (i_tvalid),
        .i_tready (i_tready1),
        .o_tdata  (o_tdata1),
        .o_tlast  (o_tlast1),
        .o_tvalid (o_tvalid1),
        .o_tready (o_tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] expand_ref(input bit mode_iq, input logic [7:0] sym);
        if (mode_iq)
            return (32'(sym >> 4) << 28) | (32'(sym & 8'h0F) << 12);
        return 32'(sym) << 24;
    endfunction

    // Compares both DUTs against the model for the current cycle, then advances the model
    // by whatever handshakes will occur at the coming edge.
    task automatic check_cycle();
        int          lane_off[4] = '{8, 16, 24, 0};
        logic        exp_valid, exp_ready, exp_last;
        logic [31:0] exp0, exp1;
        exp_valid = (model_q.size() != 0);
        exp_ready = (model_q.size() == 0) || (model_q.size() == 1 && o_tready);
        exp_last  = exp_valid ? model_q[0].last : 1'b0;
        exp0      = exp_valid ? expand_ref(1'b0, model_q[0].sym) : 32'h0;
        exp1      = exp_valid ? expand_ref(1'b1, model_q[0].sym) : 32'h0;

        check_output("valid0", {31'b0, o_tvalid0}, {31'b0, exp_valid});
        check_output("valid1", {31'b0, o_tvalid1}, {31'b0, exp_valid});
        check_output("ready0", {31'b0, i_tready0}, {31'b0, exp_ready});
        check_output("ready1", {31'b0, i_tready1}, {31'b0, exp_ready});
        check_output("data0",  o_tdata0, exp0);
        check_output("data1",  o_tdata1, exp1);
        check_output("last0",  {31'b0, o_tlast0}, {31'b0, exp_last});
        check_output("last1",  {31'b0, o_tlast1}, {31'b0, exp_last});

        last_out_valid = exp_valid;
        last_in_fire   = reset && i_tvalid && exp_ready;
        if (reset) begin
            if (exp_valid && o_tready) void'(model_q.pop_front());
            if (last_in_fire) begin
                for (int i = 0; i < 4; i++) begin
                    model_q.push_back('{sym: 8'((i_tdata >> lane_off[i]) & 32'hFF),
                                        last: i_tlast && (i == 3)});
                end
            end
        end
    endtask

    task automatic apply_stimulus(input logic vld, input logic [31:0] data,
                                  input logic last, input logic ordy);
        @(negedge clk);
        i_tvalid = vld;
        i_tdata  = data;
        i_tlast  = last;
        o_tready = ordy;
        #1;
        check_cycle();
    endtask

    initial begin
        int idx;
        int valid_beats;
        logic [31:0] words[3] = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF};

        reset    = 1'b0;
        i_tvalid = 1'b0;
        i_tdata  = 32'h0;
        i_tlast  = 1'b0;
        o_tready = 1'b1;

        // Reset held, then the first cycle after release.
        apply_stimulus(1'b0, 32'hFFFFFFFF, 1'b1, 1'b1);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_cycle();

        // Mode-0 byte order and single-word packet tlast.
        apply_stimulus(1'b1, 32'h44332211, 1'b1, 1'b1);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
        check_output("dir_lane0", o_tdata0, 32'h22000000);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
        check_output("dir_lane1", o_tdata0, 32'h33000000);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
        check_output("dir_lane2", o_tdata0, 32'h44000000);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
        check_output("dir_lane3", o_tdata0, 32'h11000000);
        check_output("dir_tlast", {31'b0, o_tlast0}, 32'h1);

        // Mode-1 nibble placement.
        apply_stimulus(1'b1, 32'h0000A500, 1'b0, 1'b1);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
        check_output("dir_mode1", o_tdata1, 32'hA0005000);
        for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);

        // Three words streamed back to back: output must be a gap-free run of 12 beats.
        idx = 0;
        valid_beats = 0;
        for (int c = 0; c < 20; c++) begin
            if (idx < 3) apply_stimulus(1'b1, words[idx], idx == 2, 1'b1);
            else         apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
            if (last_out_valid) valid_beats++;
            if (last_in_fire) idx++;
            if (idx == 3 && !last_out_valid && valid_beats > 0) break;
        end
        check_output("stream_words", 32'(idx), 32'd3);
        check_output("stream_beats", 32'(valid_beats), 32'd12);

        // Backpressure for five cycles while lane1 is presented.
        apply_stimulus(1'b1, 32'hCAFEF00D, 1'b0, 1'b1);
        apply_stimulus(1'b1, 32'h11111111, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 32'h22222222, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);

        // Reset while lane2 of a tlast word is held.
        apply_stimulus(1'b1, 32'h5A5A5A5A, 1'b1, 1'b1);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        model_q.delete();
        check_cycle();
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_cycle();
        apply_stimulus(1'b1, 32'h0F1E2D3C, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);

        // Random traffic with random backpressure.
        for (int c = 0; c < 800; c++) begin
            apply_stimulus(1'(($urandom % 10) < 7), $urandom, 1'($urandom % 2),
                           1'(($urandom % 4) != 0));
        end
        for (int i = 0; i < 6; i++) apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
